wb_stage: RTL and testbench

- Write-back stage directly downstream of the execute/memory stage.
- Latches the 70-bit execute-to-writeback bus through the valid/allowin handshake.
- Owns the 32x32 architectural register file: one write port, two combinational read ports serving decode.
- Drives the writeback forwarding bus and the debug trace port. Retired-instruction counting is optional.

---
 rtl/wb_stage.sv | 139 +++++++++++++
 tb/tb_wb_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: write-back pipeline stage.
//
// Latches the execute-to-writeback bus through the valid/allowin handshake,
// owns the 32x32 architectural register file (one write port, two
// combinational read ports with write-through bypass), and drives the
// writeback forwarding bus plus the debug trace port.
//
// Optional feature: define WB_RETIRE_CNT_EN to add a 64-bit retired
// instruction counter on port retire_cnt.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   es_to_ws_valid      upstream holds a valid instruction
//   ws_allowin          stage can accept this cycle
//   es_to_ws_bus        {gr_we, dest[4:0], result[31:0], pc[31:0]}
//   ws_forward_bus      {data[31:0], dest[4:0]}, zero when no write
//   rf_raddr1/2         register file read addresses
//   rf_rdata1/2         register file read data
//   debug_wb_*          trace of the retiring instruction
//   retire_cnt          retired-instruction count (WB_RETIRE_CNT_EN only)

module wb_stage #(
    parameter int          ES_TO_WS_BUS_WD = 70,
    parameter int          FORWARD_BUS_WD  = 37,
    parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       es_to_ws_valid,
    output logic                       ws_allowin,
    input  logic [ES_TO_WS_BUS_WD-1:0] es_to_ws_bus,
    output logic [FORWARD_BUS_WD-1:0]  ws_forward_bus,
    input  logic [4:0]                 rf_raddr1,
    output logic [31:0]                rf_rdata1,
    input  logic [4:0]                 rf_raddr2,
    output logic [31:0]                rf_rdata2,
    output logic [31:0]                debug_wb_pc,
    output logic [3:0]                 debug_wb_rf_we,
    output logic [4:0]                 debug_wb_rf_wnum,
    output logic [31:0]                debug_wb_rf_wdata
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]                retire_cnt
`endif
);

    logic                       ws_valid;
    logic [ES_TO_WS_BUS_WD-1:0] ws_bus_r;
    logic [31:0]                rf [1:31];

    logic        ws_ready_go;
    logic        ws_gr_we;
    logic [4:0]  ws_dest;
    logic [31:0] ws_result;
    logic [31:0] ws_pc;
    logic        ws_live;
    logic        rf_we;

    assign ws_gr_we  = ws_bus_r[69];
    assign ws_dest   = ws_bus_r[68:64];
    assign ws_result = ws_bus_r[63:32];
    assign ws_pc     = ws_bus_r[31:0];

    assign ws_ready_go = 1'b1;
    assign ws_allowin  = !ws_valid || ws_ready_go;

    // Reset is synchronous, so the pipeline register may still hold a valid
    // instruction during the reset cycle; masking with reset keeps that
    // instruction from writing, forwarding or appearing on the trace.
    assign ws_live = ws_valid && !reset;
    assign rf_we   = ws_live && ws_gr_we && (ws_dest != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid <= 1'b0;
            ws_bus_r <= '0;
        end else if (ws_allowin) begin
            ws_valid <= es_to_ws_valid;
            if (es_to_ws_valid) begin
                ws_bus_r <= es_to_ws_bus;
            end
        end
    end

    // r0 has no storage; rf_we already excludes dest 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (rf_we) begin
            rf[ws_dest] <= ws_result;
        end
    end

    // Write-through bypass so decode sees a value in the same cycle it is
    // being written.
    always_comb begin
        rf_rdata1 = '0;
        if (rf_raddr1 != 5'd0) begin
            if (rf_we && (rf_raddr1 == ws_dest)) begin
                rf_rdata1 = ws_result;
            end else begin
                rf_rdata1 = rf[rf_raddr1];
            end
        end
    end

    always_comb begin
        rf_rdata2 = '0;
        if (rf_raddr2 != 5'd0) begin
            if (rf_we && (rf_raddr2 == ws_dest)) begin
                rf_rdata2 = ws_result;
            end else begin
                rf_rdata2 = rf[rf_raddr2];
            end
        end
    end

    // An all-zero bus names r0, which consumers treat as a harmless no-op.
    assign ws_forward_bus = rf_we ? {ws_result, ws_dest} : '0;

    assign debug_wb_pc       = ws_live ? ws_pc : RESET_PC;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = reset ? 5'd0  : ws_dest;
    assign debug_wb_rf_wdata = reset ? 32'd0 : ws_result;

`ifdef WB_RETIRE_CNT_EN
    // Counts every retiring instruction, stores included; wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt <= '0;
        end else if (ws_valid) begin
            retire_cnt <= retire_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_to_ws_valid;
    logic        ws_allowin;
    logic [69:0] es_to_ws_bus;
    logic [36:0] ws_forward_bus;
    logic [4:0]  rf_raddr1;
    logic [31:0] rf_rdata1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata2;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: architectural register contents after every retired
    // instruction, the instruction currently in write-back, and a retire count.
    logic [31:0] arch [32];
    logic        cur_valid;
    logic [69:0] cur_bus;
    logic [63:0] cnt;

    wb_stage dut (
        .clk              (clk),
        .reset            (reset),
        .es_to_ws_valid   (es_to_ws_valid),
        .ws_allowin       (ws_allowin),
        .es_to_ws_bus     (es_to_ws_bus),
        .ws_forward_bus   (ws_forward_bus),
        .rf_raddr1        (rf_raddr1),
        .rf_rdata1        (rf_rdata1),
        .rf_raddr2        (rf_raddr2),
        .rf_rdata2        (rf_rdata2),
        .debug_wb_pc      (debug_wb_pc),
        .debug_wb_rf_we   (debug_wb_rf_we),
        .debug_wb_rf_wnum (debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt       (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [69:0] mk(input logic we, input logic [4:0] d,
                                       input logic [31:0] r, input logic [31:0] pc);
        return {we, d, r, pc};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Does the instruction now in write-back actually commit a register?
    function automatic logic commits();
        return cur_valid && !reset && cur_bus[69] && (cur_bus[68:64] != 5'd0);
    endfunction

    // Value a reader should see: the newest architectural value, counting the
    // instruction retiring right now.
    function automatic logic [31:0] arch_value(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (commits() && cur_bus[68:64] == a) return cur_bus[63:32];
        return arch[a];
    endfunction

    task automatic check_all(input string tag);
        logic w;
        w = commits();
        chk({tag, ".allowin"}, 64'(ws_allowin), 64'(1'b1));
        chk({tag, ".fwd"}, 64'(ws_forward_bus), w ? 64'({cur_bus[63:32], cur_bus[68:64]}) : 64'd0);
        chk({tag, ".pc"}, 64'(debug_wb_pc), (cur_valid && !reset) ? 64'(cur_bus[31:0]) : 64'(RESET_PC));
        chk({tag, ".we"}, 64'(debug_wb_rf_we), w ? 64'hf : 64'h0);
        chk({tag, ".wnum"}, 64'(debug_wb_rf_wnum), reset ? 64'd0 : 64'(cur_bus[68:64]));
        chk({tag, ".wdata"}, 64'(debug_wb_rf_wdata), reset ? 64'd0 : 64'(cur_bus[63:32]));
        chk({tag, ".rd1"}, 64'(rf_rdata1), 64'(arch_value(rf_raddr1)));
        chk({tag, ".rd2"}, 64'(rf_rdata2), 64'(arch_value(rf_raddr2)));
`ifdef WB_RETIRE_CNT_EN
        chk({tag, ".cnt"}, retire_cnt, cnt);
`endif
    endtask

    // Drive one cycle, advance the model across the edge, then check.
    task automatic step(input string tag, input logic rst, input logic v,
                        input logic [69:0] b, input logic [4:0] a1, input logic [4:0] a2);
        reset          = rst;
        es_to_ws_valid = v;
        es_to_ws_bus   = b;
        rf_raddr1      = a1;
        rf_raddr2      = a2;
        @(posedge clk);
        if (rst) begin
            cur_valid = 1'b0;
            cur_bus   = '0;
            cnt       = '0;
            for (int i = 0; i < 32; i++) arch[i] = '0;
        end else begin
            if (cur_valid && cur_bus[69] && cur_bus[68:64] != 5'd0)
                arch[cur_bus[68:64]] = cur_bus[63:32];
            if (cur_valid) cnt = cnt + 64'd1;
            cur_valid = v;
            if (v) cur_bus = b;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [69:0] rb;
        logic        rv;
        logic        rr;
        cur_valid = 1'b0;
        cur_bus   = '0;
        cnt       = '0;
        for (int i = 0; i < 32; i++) arch[i] = '0;
        reset = 1'b1; es_to_ws_valid = 1'b0; es_to_ws_bus = '0;
        rf_raddr1 = '0; rf_raddr2 = '0;

        // Reset held three cycles.
        step("rst0", 1, 0, '0, 5, 5);
        step("rst1", 1, 0, '0, 5, 0);
        step("rst2", 1, 0, '0, 5, 31);

        // Single write, bypass cycle then storage cycle.
        step("wr3", 0, 1, mk(1, 3, 32'hDEADBEEF, 32'h1c000010), 3, 0);
        chk("wr3.fwd_lit", 64'(ws_forward_bus), 64'({32'hDEADBEEF, 5'd3}));
        step("wr3_hold", 0, 0, '0, 3, 3);
        chk("wr3_hold.rd_lit", 64'(rf_rdata1), 64'h0000_0000_DEAD_BEEF);

        // Write to r0 is dropped.
        step("r0", 0, 1, mk(1, 0, 32'h12345678, 32'h1c000020), 3, 0);
        step("r0_after", 0, 0, '0, 0, 0);

        // Back-to-back writes to r7.
        step("b2b1", 0, 1, mk(1, 7, 32'h1, 32'h1c000030), 7, 7);
        step("b2b2", 0, 1, mk(1, 7, 32'h2, 32'h1c000034), 7, 7);
        step("b2b_idle", 0, 0, '0, 7, 7);
        chk("b2b_idle.rd_lit", 64'(rf_rdata2), 64'd2);

        // Store-like, no register write.
        step("st", 0, 1, mk(0, 9, 32'hFFFF, 32'h1c000040), 9, 9);
        step("st_after", 0, 0, '0, 9, 3);

        // Reset mid-stream discards a pending r4 write.
        step("mid_wr", 0, 1, mk(1, 4, 32'hAA, 32'h1c000050), 4, 4);
        step("mid_rst", 1, 0, '0, 4, 3);
        step("mid_post", 0, 0, '0, 4, 3);
        chk("mid_post.r4_lit", 64'(rf_rdata1), 64'd0);

        // Randomized traffic with a narrow dest range to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            rr = ($urandom_range(0, 49) == 0);
            rv = ($urandom_range(0, 3) != 0);
            rb = mk(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                    $urandom, 32'h1c000000 + 32'($urandom_range(0, 4095) * 4));
            step("rnd", rr, rv, rb, 5'($urandom_range(0, 8)), 5'($urandom_range(0, 8)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
